sgd_update_sequencer: RTL

- Time-multiplexed SGD engine: applies param_new = param - (lr*grad)[23:8] (Q8.8) to every entry of a parameter/gradient memory using one multiply-subtract unit.
- Sits between the training controller and the packed weight+bias memory.
- Sequences one full pass per start request; write-back is in place.
- Replaces the fully parallel per-parameter update array for larger networks.

---
 rtl/sgd_update_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sgd_update_sequencer.sv
// Time-multiplexed SGD update: walks the parameter/gradient memory once per start,
// writing param - (lr*grad)[23:8] back in place through a single multiply-subtract path.
module sgd_update_sequencer #(
    parameter int unsigned NUM_PARAMS = 13,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       lr,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       p_rdata,
    input  logic [15:0]       g_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [15:0]       pass_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PARAMS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t              state_q;
    logic [15:0]         lr_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                dvalid_q;
    logic [ADDR_W-1:0]   daddr_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [15:0]         wr_data_q;
    logic [15:0]         pass_cnt_q;

    logic signed [31:0]  prod;
    logic [15:0]         wr_data_d;

    // Arithmetic shift then truncate keeps bits [23:8], i.e. floor division by 256.
    always_comb begin
        prod      = 32'($signed(lr_q)) * 32'($signed(g_rdata));
        wr_data_d = p_rdata - 16'(prod >>> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lr_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            dvalid_q   <= 1'b0;
            daddr_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pass_cnt_q <= '0;
        end else begin
            done_q   <= 1'b0;
            dvalid_q <= rd_en_q;
            wr_en_q  <= dvalid_q;
            if (rd_en_q) begin
                daddr_q <= rd_addr_q;
            end
            if (dvalid_q) begin
                wr_addr_q <= daddr_q;
                wr_data_q <= wr_data_d;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        lr_q      <= lr;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                RUN: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                        state_q    <= FINISH;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_cnt_q <= pass_cnt_q + 16'd1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pass_count = pass_cnt_q;

endmodule
